// File: rtl/fifo_sched_pkg.sv
// fifo_sched shared types: read FSM states, default widths,
// counter saturation constant and saturating increment helper.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_HOLD
  } state_e;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_SRC_W  = 2;
  localparam int DEF_DST_W  = 2;
  localparam int DEF_DATA_W = 8;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fifo_sched_arb.sv
// rr_arbiter: round-robin one-hot grant among req when en is high.
// Ports: clk, rst (async high), req, en -> grant; holds rr pointer.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_nxt;
  logic [N_REQ-1:0] w_elig;
  logic             w_found;
  int               w_idx;

  assign w_elig = en ? req : '0;

  // Scan from the pointer upward; first eligible wins.
  always_comb begin
    grant   = '0;
    w_nxt   = r_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && w_elig[PW'(w_idx)]) begin
        w_found            = 1'b1;
        grant[PW'(w_idx)]  = 1'b1;
        w_nxt = PW'((w_idx + 1) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else     r_ptr <= w_nxt;
  end

endmodule

// File: rtl/fifo_sched.sv
// fifo_sched: shares one FIFO among producers (rr write arbiter)
// and routes popped words to the consumer named by their dst tag.
// Ports: req_* producers, f_* FIFO side, out_* consumers, wr/rd_cnt.
module fifo_sched
  import fifo_sched_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int SRC_W  = DEF_SRC_W,
  parameter int DST_W  = DEF_DST_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*SRC_W-1:0]  req_src,
  input  logic [N_REQ*DST_W-1:0]  req_dst,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_grant,
  output logic [SRC_W-1:0]        f_src_in,
  output logic [DST_W-1:0]        f_dst_in,
  output logic [DATA_W-1:0]       f_data_in,
  output logic                    f_writep,
  output logic                    f_readp,
  input  logic [SRC_W-1:0]        f_src_out,
  input  logic [DST_W-1:0]        f_dst_out,
  input  logic [DATA_W-1:0]       f_data_out,
  input  logic                    f_emptyp,
  input  logic                    f_fullp,
  output logic [2**DST_W-1:0]     out_valid,
  input  logic [2**DST_W-1:0]     out_ready,
  output logic [SRC_W-1:0]        out_src,
  output logic [DATA_W-1:0]       out_data,
  output logic [15:0]             wr_cnt,
  output logic [15:0]             rd_cnt
);

  localparam int NC = 2**DST_W;
  localparam logic [NC-1:0] ONE = {{(NC-1){1'b0}}, 1'b1};

  logic w_en;
  state_e            r_state;
  logic [SRC_W-1:0]  r_src;
  logic [DST_W-1:0]  r_dst;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_wr;
  logic [15:0]       r_rd;

  // Reset also gates grants so nothing is written while held.
  assign w_en = ~f_fullp & ~rst;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (w_en),
    .grant (req_grant)
  );

  always_comb begin
    f_src_in  = '0;
    f_dst_in  = '0;
    f_data_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_grant[i]) begin
        f_src_in  = req_src[i*SRC_W +: SRC_W];
        f_dst_in  = req_dst[i*DST_W +: DST_W];
        f_data_in = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign f_writep = |req_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_data  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      if (f_writep) r_wr <= sat_inc(r_wr);
      unique case (r_state)
        S_IDLE: if (!f_emptyp) r_state <= S_READ;
        S_READ: r_state <= S_CAPT;
        S_CAPT: begin
          r_src   <= f_src_out;
          r_dst   <= f_dst_out;
          r_data  <= f_data_out;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready[r_dst]) begin
            r_rd    <= sat_inc(r_rd);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign f_readp   = (r_state == S_READ);
  assign out_valid = (r_state == S_HOLD) ? (ONE << r_dst) : '0;
  assign out_src   = r_src;
  assign out_data  = r_data;
  assign wr_cnt    = r_wr;
  assign rd_cnt    = r_rd;

endmodule

// File: tb/tb_fifo_sched.sv
// Bench for fifo_sched: FIFO model, queue-based reference model,
// directed cases plus randomized stress.
module tb_fifo_sched;

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
    logic [7:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [7:0]  req_src;
  logic [7:0]  req_dst;
  logic [31:0] req_data;
  logic [3:0]  req_grant;
  logic [1:0]  f_src_in;
  logic [1:0]  f_dst_in;
  logic [7:0]  f_data_in;
  logic        f_writep;
  logic        f_readp;
  logic [1:0]  f_src_out;
  logic [1:0]  f_dst_out;
  logic [7:0]  f_data_out;
  logic        f_emptyp;
  logic        f_fullp;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  out_src;
  logic [7:0]  out_data;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  fifo_sched #(
    .N_REQ(4), .SRC_W(2), .DST_W(2), .DATA_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_src(req_src),
    .req_dst(req_dst), .req_data(req_data),
    .req_grant(req_grant),
    .f_src_in(f_src_in), .f_dst_in(f_dst_in),
    .f_data_in(f_data_in), .f_writep(f_writep),
    .f_readp(f_readp),
    .f_src_out(f_src_out), .f_dst_out(f_dst_out),
    .f_data_out(f_data_out),
    .f_emptyp(f_emptyp), .f_fullp(f_fullp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_data(out_data),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  always #5 clk = ~clk;

  // 8-deep FIFO; read data appears the cycle after readp.
  word_t fmem [8];
  int    fcnt, fwp, frp;
  word_t fout;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= 0; fwp <= 0; frp <= 0; fout <= '0;
    end else begin
      if (f_writep && fcnt < 8) begin
        fmem[fwp] <= {f_src_in, f_dst_in, f_data_in};
        fwp <= (fwp + 1) % 8;
      end
      if (f_readp && fcnt > 0) begin
        fout <= fmem[frp];
        frp  <= (frp + 1) % 8;
      end
      fcnt <= fcnt + ((f_writep && fcnt < 8) ? 1 : 0)
                   - ((f_readp && fcnt > 0) ? 1 : 0);
    end
  end
  assign f_emptyp = (fcnt == 0);
  assign f_fullp  = (fcnt == 8);
  assign {f_src_out, f_dst_out, f_data_out} = fout;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int arb_idx(input logic [3:0] v,
                                 input logic full,
                                 input int ptr);
    if (full) return -1;
    for (int k = 0; k < 4; k++)
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // Reference model: written words in order, delivered in order.
  word_t m_q[$];
  int    m_ptr = 0;
  int    m_wr = 0;
  int    m_rd = 0;
  int    exp_seq[4];
  bit    stress_on = 0;

  always @(negedge clk) begin
    int    g;
    word_t w;
    word_t e;
    if (rst) begin
      m_ptr = 0; m_wr = 0; m_rd = 0;
      m_q.delete();
      for (int p = 0; p < 4; p++) exp_seq[p] = 0;
    end else begin
      g = arb_idx(req_valid, f_fullp, m_ptr);
      e = '0;
      if (g >= 0) begin
        e.src  = req_src[g*2 +: 2];
        e.dst  = req_dst[g*2 +: 2];
        e.data = req_data[g*8 +: 8];
      end
      chk("grant", req_grant, (g >= 0) ? (4'b0001 << g) : 4'b0);
      chk("writep", f_writep, (g >= 0) ? 1 : 0);
      chk("f_in", {f_src_in, f_dst_in, f_data_in}, e);
      chk("wr_cnt", wr_cnt, m_wr);
      chk("rd_cnt", rd_cnt, m_rd);
      chk("readp_empty", f_readp & f_emptyp, 0);
      chk("writep_full", f_writep & f_fullp, 0);
      if (out_valid != 0) begin
        if (m_q.size() == 0) begin
          chk("valid_noword", out_valid, 0);
        end else begin
          w = m_q[0];
          chk("out_valid", out_valid, 4'b0001 << w.dst);
          chk("out_src", out_src, w.src);
          chk("out_data", out_data, w.data);
          if (out_ready[w.dst]) begin
            if (stress_on) begin
              chk("prod_order", out_data[5:0],
                  exp_seq[out_src] % 64);
              exp_seq[out_src]++;
            end
            void'(m_q.pop_front());
            m_rd = (m_rd < 65535) ? m_rd + 1 : m_rd;
          end
        end
      end
      if (g >= 0) begin
        m_q.push_back(e);
        m_ptr = (g + 1) % 4;
        m_wr  = (m_wr < 65535) ? m_wr + 1 : m_wr;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    req_valid = '0;
    out_ready = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 4'hF;
    n = 0;
    while (m_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, m_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [3:0] rr [5];
    logic [3:0] last;
    logic [3:0] gl;
    int n, issued, loaded, cyc;
    logic [5:0] seq [4];

    rst = 1'b1;
    req_valid = '0; req_src = '0; req_dst = '0;
    req_data = '0; out_ready = '0;
    #1;
    chk("rst_grant", req_grant, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_readp", f_readp, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_wr", wr_cnt, 0);
    chk("init_data", {out_src, out_data}, 0);

    // Round-robin with all producers requesting.
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) begin
      req_src[p*2 +: 2]  = 2'(p);
      req_dst[p*2 +: 2]  = 2'(p);
      req_data[p*8 +: 8] = 8'h10 + 8'(p);
    end
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rr[i] = req_grant;
    end
    @(posedge clk); #1 req_valid = '0;
    chk("rr0", rr[0], 4'b0001);
    chk("rr1", rr[1], 4'b0010);
    chk("rr2", rr[2], 4'b0100);
    chk("rr3", rr[3], 4'b1000);
    chk("rr4", rr[4], 4'b0001);
    @(negedge clk);
    chk("rr_wr_cnt", wr_cnt, 5);

    // Asynchronous reset while a word is held.
    n = 0;
    while (out_valid == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached", (out_valid != 0), 1);
    #2 req_valid = 4'hF;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_grant", req_grant, 0);
    chk("arst_writep", f_writep, 0);
    chk("arst_readp", f_readp, 0);
    chk("arst_out", {out_src, out_data}, 0);
    chk("arst_cnt", {wr_cnt, rd_cnt}, 0);
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Routing and pop-to-present latency.
    @(posedge clk); #1;
    req_src[1:0] = 2'd2;
    req_dst[1:0] = 2'd3;
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("route_grant", req_grant, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("route_nempty", f_emptyp, 0);
    chk("route_v0", out_valid, 0);
    @(negedge clk);
    chk("route_readp1", f_readp, 1);
    chk("route_v1", out_valid, 0);
    @(negedge clk);
    chk("route_readp2", f_readp, 0);
    chk("route_v2", out_valid, 0);
    @(negedge clk);
    chk("route_v3", out_valid, 4'b1000);
    chk("route_src", out_src, 2);
    chk("route_data", out_data, 8'hA5);
    @(posedge clk); #1 out_ready = 4'b0111;
    repeat (3) begin
      @(negedge clk);
      chk("route_stall", out_valid, 4'b1000);
    end
    @(posedge clk); #1 out_ready = 4'b1000;
    @(posedge clk); #1 out_ready = '0;
    @(negedge clk);
    chk("route_released", out_valid, 0);
    chk("route_rd_cnt", rd_cnt, 1);

    // Full boundary.
    do_reset();
    @(posedge clk); #1;
    req_src  = 8'h20;
    req_dst  = 8'h24;
    req_data = 32'h0032_0030;
    req_valid = 4'b0101;
    last = '0;
    n = 0;
    while (!f_fullp && n < 40) begin
      @(negedge clk);
      if (|req_grant) last = req_grant;
      n++;
    end
    chk("full_reached", f_fullp, 1);
    chk("full_last", last, 4'b0001);
    repeat (3) begin
      @(negedge clk);
      chk("full_nowrite", f_writep, 0);
    end
    @(posedge clk); #1 out_ready = 4'hF;
    @(posedge clk); #1 out_ready = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_grant == 0 && n < 20);
    chk("full_next", req_grant, 4'b0100);
    drain("full_drain");

    // Randomized stress.
    do_reset();
    stress_on = 1;
    for (int p = 0; p < 4; p++) seq[p] = '0;
    issued = 0; loaded = 0; cyc = 0;
    while ((issued < 500 || loaded < 500) && cyc < 20000) begin
      @(negedge clk);
      gl = req_grant;
      cyc++;
      @(posedge clk); #1;
      for (int p = 0; p < 4; p++) begin
        if (gl[p]) begin
          issued++;
          req_valid[p] = 1'b0;
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (!req_valid[p] && loaded < 500 &&
            $urandom_range(0, 1) == 1) begin
          req_src[p*2 +: 2]  = 2'(p);
          req_dst[p*2 +: 2]  = 2'($urandom_range(0, 3));
          req_data[p*8 +: 8] = {2'(p), seq[p]};
          seq[p] = seq[p] + 6'd1;
          req_valid[p] = 1'b1;
          loaded++;
        end
      end
      out_ready = ($urandom_range(0, 3) == 0) ? 4'h0
                : 4'($urandom_range(0, 15));
    end
    chk("stress_issued", issued, 500);
    drain("stress_drain");
    chk("stress_wr", wr_cnt, 500);
    chk("stress_rd", rd_cnt, 500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
